dvs_luma_frontend: RTL and testbench
====================================

# dvs_luma_frontend

Upstream stage of the gray-code bit-plane (gcbp) block in the stabilization pipeline. Takes the raw YCbCr 4:2:2 video stream (one pixel per clock while data-enable is high, with hsync and vsync), extracts and horizontally decimates luma, and tracks frame and line position. It produces exactly the strobes gcbp consumes: 9-bit luma sample with a valid pulse, new-line and new-frame pulses, and a line count. It also flags lines that arrive beyond the configured frame height.

## Interface
Parameters:
- ACTIVE_PIXELS, 640: input pixels per line that are processed; later pixels are ignored.
- ACTIVE_LINES, 480: lines per frame that are processed; later lines are ignored and flagged.

Ports:
- i_clk  in  1  pixel clock; one clock, all logic on its rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_video_data  in  16  YCbCr 4:2:2 pixel; Y in [15:8], Cb/Cr in [7:0] (ignored).
- i_video_de  in  1  data enable; high = valid pixel this cycle.
- i_video_vsync  in  1  vertical sync, active high; its rising edge marks a frame boundary.
- o_luma_data  out  9  luma sample to gcbp.
- o_luma_data_valid  out  1  one-cycle strobe qualifying o_luma_data.
- o_new_line  out  1  one-cycle pulse at the start of each processed line.
- o_new_frame  out  1  one-cycle pulse, coincident with o_new_line of line 0.
- o_line_cnt  out  9  index of the current line, 0..ACTIVE_LINES-1.
- o_line_overrun  out  1  one-cycle pulse when a line starts after ACTIVE_LINES lines.

## Operation
- Edge detection: vsync and DE are registered once, and rising and falling edges are derived from the registered and current values.
- FSM states: WAIT_VSYNC (after reset), WAIT_LINE, ACTIVE_LINE, FRAME_DONE.
- WAIT_VSYNC -> WAIT_LINE on a vsync rise; sets the frame_first flag.
- WAIT_LINE -> ACTIVE_LINE on a DE rise:
  - Pulse o_new_line.
  - If frame_first is set: pulse o_new_frame, load o_line_cnt = 0 and clear frame_first. Otherwise increment o_line_cnt.
  - Clear the pixel counter.
- ACTIVE_LINE -> WAIT_LINE on a DE fall, when o_line_cnt < ACTIVE_LINES-1.
- ACTIVE_LINE -> FRAME_DONE on a DE fall, when o_line_cnt = ACTIVE_LINES-1.
- FRAME_DONE: a DE rise pulses o_line_overrun; no other output changes.
- Frame resync: a vsync rise in any state goes to WAIT_LINE, sets frame_first and discards any partial pair.
  - When a vsync rise and a DE rise land in the same cycle, vsync wins and that line is not started.
- Pixel handling in ACTIVE_LINE (with DVS_LUMA_HDECIM_EN):
  - Pixel counter p counts DE-high cycles; pixels with p >= ACTIVE_PIXELS are ignored.
  - Even p: latch Y.
  - Odd p: o_luma_data = Y_even + Y_odd. This is a 9-bit unsigned sum with no truncation, maximum 510. Pulse valid.
  - A trailing unpaired pixel (DE falls after an even p) is dropped.
- Reset: all state is cleared to WAIT_VSYNC. No output activity occurs until a vsync rise, even if reset releases mid-frame.

## Timing
- Reset values: o_luma_data = 0; o_luma_data_valid, o_new_line, o_new_frame, o_line_overrun = 0; o_line_cnt = 0.
- All outputs are registered.
- o_new_line / o_new_frame / o_line_cnt update 1 cycle after the first DE-high sample of a line.
- o_luma_data_valid follows 1 cycle after the odd pixel is sampled.
  - This gives at least 1 cycle from o_new_line to the first valid.
  - Valid strobes are at most every 2nd cycle.
- o_luma_data holds its value between valid strobes.
- o_line_cnt holds its value until the next o_new_line.

## Configuration
- DVS_LUMA_HDECIM_EN defined: 2:1 horizontal pair summing as described above.
  - ACTIVE_PIXELS/2 valid strobes per line.
- DVS_LUMA_HDECIM_EN undefined: no decimation.
  - Every active pixel produces o_luma_data = {Y, 1'b0}, which keeps the same 9-bit range.
  - Valid on every pixel, 1 cycle after sampling; ACTIVE_PIXELS strobes per line.
  - The even-pixel latch is removed.

## Structure
- Package dvs_luma_pkg holds:
  - width constants LUMA_W = 9 and LINE_CNT_W = 9;
  - default ACTIVE_PIXELS and ACTIVE_LINES;
  - the FSM state enum.
- Sub-module dvs_sync_edge: a register plus rising/falling edge detector, with asynchronous active-high reset. It is instantiated once each for vsync and DE.

## Test plan
- Reset held, then released mid-line with DE high -> no output pulses until a vsync rise; all outputs stay 0.
- Vsync rise, then DE high for 640 cycles with Y alternating 0x10/0x20 (HDECIM_EN) -> o_new_frame and o_new_line together with o_line_cnt = 0; 320 valids spaced 2 cycles apart, each with o_luma_data = 0x030; first valid 1 cycle after o_new_line.
- 481 DE lines after one vsync (ACTIVE_LINES = 480) -> o_line_cnt runs 0..479; line 481 produces one o_line_overrun pulse and no new_line or valid.
- Line with 5 DE cycles, Y = 0xFF each -> 2 valids, each with o_luma_data = 0x1FE; 5th pixel dropped.
- Vsync rise mid-line after 3 pixels, then a DE rise -> partial pair discarded; o_new_frame with o_line_cnt = 0.
- HDECIM_EN undefined, 4 pixels with Y = 0x80 -> 4 consecutive valids, each with o_luma_data = 0x100.

Source files
------------

// File: rtl/dvs_luma_pkg.sv
// dvs_luma_pkg: shared widths, default frame geometry and FSM states for the luma front end
package dvs_luma_pkg;
  localparam int LUMA_W = 9;
  localparam int LINE_CNT_W = 9;
  localparam int ACTIVE_PIXELS_DEF = 640;
  localparam int ACTIVE_LINES_DEF = 480;
  typedef enum logic [1:0] {WAIT_VSYNC, WAIT_LINE, ACTIVE_LINE, FRAME_DONE} state_t;
endpackage

// File: rtl/dvs_sync_edge.sv
// dvs_sync_edge: registers a level once and flags its rising/falling edges against the live value
// Ports: clk, rst (async, active high), d (level), rise/fall (combinational edge flags).
module dvs_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic q;
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= 1'b0;
    else q <= d;
  assign rise = d & ~q;
  assign fall = ~d & q;
endmodule

// File: rtl/dvs_luma_frontend.sv
// dvs_luma_frontend: extracts luma from a YCbCr 4:2:2 stream and tracks line/frame position for gcbp
// Ports: i_clk, i_reset (async, active high); i_video_data/de/vsync raw video in;
//   o_luma_data/o_luma_data_valid luma samples; o_new_line, o_new_frame, o_line_cnt, o_line_overrun.
// Build option: DVS_LUMA_HDECIM_EN enables 2:1 horizontal pair summing; otherwise every pixel is {Y,0}.
module dvs_luma_frontend
  import dvs_luma_pkg::*;
#(
  parameter int ACTIVE_PIXELS = ACTIVE_PIXELS_DEF,
  parameter int ACTIVE_LINES = ACTIVE_LINES_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [15:0]           i_video_data,
  input  logic                  i_video_de,
  input  logic                  i_video_vsync,
  output logic [LUMA_W-1:0]     o_luma_data,
  output logic                  o_luma_data_valid,
  output logic                  o_new_line,
  output logic                  o_new_frame,
  output logic [LINE_CNT_W-1:0] o_line_cnt,
  output logic                  o_line_overrun
);
  localparam int P_W = $clog2(ACTIVE_PIXELS + 1);
  state_t state, state_nx;
  logic vs_rise, vs_fall, de_rise, de_fall;
  logic frame_first, start, pix_use, overrun;
  logic [P_W-1:0] p, pidx;
  logic [7:0] y;
  assign y = i_video_data[15:8];
  dvs_sync_edge u_vs (.clk(i_clk), .rst(i_reset), .d(i_video_vsync), .rise(vs_rise), .fall(vs_fall));
  dvs_sync_edge u_de (.clk(i_clk), .rst(i_reset), .d(i_video_de), .rise(de_rise), .fall(de_fall));
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) state <= WAIT_VSYNC;
    else state <= state_nx;
  always_comb begin
    state_nx = vs_rise ? WAIT_LINE :
               (state == WAIT_LINE && de_rise) ? ACTIVE_LINE :
               (state == ACTIVE_LINE && de_fall) ?
                 (o_line_cnt == LINE_CNT_W'(ACTIVE_LINES - 1) ? FRAME_DONE : WAIT_LINE) :
               state;
  end
  // The first DE-high sample is taken while still in WAIT_LINE, so it is pixel 0 of the new line.
  always_comb begin
    start = state == WAIT_LINE && de_rise && !vs_rise;
    pidx = start ? '0 : p;
    pix_use = i_video_de && !vs_rise && (start || state == ACTIVE_LINE) && pidx < P_W'(ACTIVE_PIXELS);
    overrun = state == FRAME_DONE && de_rise && !vs_rise;
  end
`ifdef DVS_LUMA_HDECIM_EN
  logic [7:0] y_even;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      y_even <= '0;
      o_luma_data <= '0;
      o_luma_data_valid <= 1'b0;
    end else begin
      if (pix_use && !pidx[0]) y_even <= y;
      if (pix_use && pidx[0]) o_luma_data <= {1'b0, y_even} + {1'b0, y};
      o_luma_data_valid <= pix_use && pidx[0];
    end
`else
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      o_luma_data <= '0;
      o_luma_data_valid <= 1'b0;
    end else begin
      if (pix_use) o_luma_data <= {y, 1'b0};
      o_luma_data_valid <= pix_use;
    end
`endif
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      frame_first <= 1'b0;
      p <= '0;
      o_new_line <= 1'b0;
      o_new_frame <= 1'b0;
      o_line_cnt <= '0;
      o_line_overrun <= 1'b0;
    end else begin
      frame_first <= vs_rise || (frame_first && !start);
      if (pix_use) p <= pidx + 1'b1;
      if (start) o_line_cnt <= frame_first ? '0 : o_line_cnt + 1'b1;
      o_new_line <= start;
      o_new_frame <= start && frame_first;
      o_line_overrun <= overrun;
    end
endmodule

// File: tb/tb_dvs_luma_frontend.sv
// tb_dvs_luma_frontend: directed self-checking bench for dvs_luma_frontend (default geometry 640x480)
module tb_dvs_luma_frontend;
`ifdef DVS_LUMA_HDECIM_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif
  logic clk = 1'b0;
  logic i_reset = 1'b1;
  logic [15:0] i_video_data = '0;
  logic i_video_de = 1'b0;
  logic i_video_vsync = 1'b0;
  logic [8:0] o_luma_data;
  logic o_luma_data_valid, o_new_line, o_new_frame, o_line_overrun;
  logic [8:0] o_line_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int nl_t[$], nf_t[$], ov_t[$], v_t[$];
  logic [8:0] v_d[$], nl_cnt[$];

  dvs_luma_frontend dut (
    .i_clk(clk), .i_reset(i_reset), .i_video_data(i_video_data), .i_video_de(i_video_de),
    .i_video_vsync(i_video_vsync), .o_luma_data(o_luma_data), .o_luma_data_valid(o_luma_data_valid),
    .o_new_line(o_new_line), .o_new_frame(o_new_frame), .o_line_cnt(o_line_cnt),
    .o_line_overrun(o_line_overrun)
  );

  always #5 clk = ~clk;

  task automatic clear_stats();
    nl_t.delete(); nf_t.delete(); ov_t.delete(); v_t.delete(); v_d.delete(); nl_cnt.delete();
  endtask

  task automatic tick(input logic de, input logic vs, input logic [7:0] y);
    i_video_de = de;
    i_video_vsync = vs;
    i_video_data = {y, 8'hA5};
    @(posedge clk);
    #1;
    cyc++;
    if (o_new_line) begin nl_t.push_back(cyc); nl_cnt.push_back(o_line_cnt); end
    if (o_new_frame) nf_t.push_back(cyc);
    if (o_line_overrun) ov_t.push_back(cyc);
    if (o_luma_data_valid) begin v_t.push_back(cyc); v_d.push_back(o_luma_data); end
  endtask

  task automatic run_line(input int n, input logic [7:0] ya, input logic [7:0] yb);
    clear_stats();
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, i[0] ? yb : ya);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic vsync_pulse();
    tick(1'b0, 1'b1, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    logic [21:0] obs;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 8'h77);
      obs = {o_luma_data, o_luma_data_valid, o_new_line, o_new_frame, o_line_cnt, o_line_overrun};
      n_cmp++;
      if (obs !== 22'd0) begin n_bad++; $display("FAIL reset_hold: got %h want 0", obs); end
    end
    i_reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick(i inside {[6:7]} ? 1'b0 : 1'b1, 1'b0, 8'h77);
      obs = {o_luma_data, o_luma_data_valid, o_new_line, o_new_frame, o_line_cnt, o_line_overrun};
      n_cmp++;
      if (obs !== 22'd0) begin n_bad++; $display("FAIL reset_release_quiet cyc %0d: got %h want 0", i, obs); end
    end
    tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_full_line();
    vsync_pulse();
    run_line(640, 8'h10, 8'h20);
    n_cmp++;
    if (nl_t.size() !== 1 || nf_t.size() !== 1) begin
      n_bad++; $display("FAIL full_new_line_frame: got nl=%0d nf=%0d want 1/1", nl_t.size(), nf_t.size());
    end else begin
      n_cmp++;
      if (nl_t[0] !== nf_t[0]) begin n_bad++; $display("FAIL full_coincident: got nl@%0d nf@%0d", nl_t[0], nf_t[0]); end
      n_cmp++;
      if (nl_cnt[0] !== 9'd0) begin n_bad++; $display("FAIL full_line_cnt: got %0d want 0", nl_cnt[0]); end
    end
    n_cmp++;
    if (v_t.size() !== (DEC ? 320 : 640)) begin
      n_bad++; $display("FAIL full_valid_count: got %0d want %0d", v_t.size(), DEC ? 320 : 640);
    end else begin
      n_cmp++;
      if (nl_t.size() != 1 || v_t[0] - nl_t[0] !== (DEC ? 1 : 0)) begin
        n_bad++; $display("FAIL full_first_valid_offset: got v@%0d want offset %0d", v_t[0], DEC ? 1 : 0);
      end
      for (int k = 0; k < v_t.size(); k++) begin
        n_cmp++;
        if (v_d[k] !== (DEC ? 9'h030 : (k[0] ? 9'h040 : 9'h020))) begin
          n_bad++; $display("FAIL full_luma[%0d]: got %h want %h", k, v_d[k], DEC ? 9'h030 : (k[0] ? 9'h040 : 9'h020));
        end
        if (k > 0) begin
          n_cmp++;
          if (v_t[k] - v_t[k-1] !== (DEC ? 2 : 1)) begin
            n_bad++; $display("FAIL full_spacing[%0d]: got %0d want %0d", k, v_t[k] - v_t[k-1], DEC ? 2 : 1);
          end
        end
      end
    end
  endtask

  task automatic test_overrun();
    vsync_pulse();
    for (int i = 0; i < 481; i++) begin
      run_line(2, 8'h11, 8'h22);
      if (i < 480) begin
        n_cmp++;
        if (nl_t.size() !== 1 || nl_cnt[0] !== 9'(i)) begin
          n_bad++; $display("FAIL ovr_line_cnt[%0d]: got nl=%0d cnt=%0d want 1/%0d", i, nl_t.size(), o_line_cnt, i);
        end
        n_cmp++;
        if (ov_t.size() !== 0) begin n_bad++; $display("FAIL ovr_early_overrun[%0d]: got %0d want 0", i, ov_t.size()); end
      end else begin
        n_cmp++;
        if (ov_t.size() !== 1) begin n_bad++; $display("FAIL ovr_pulse: got %0d want 1", ov_t.size()); end
        n_cmp++;
        if (nl_t.size() !== 0 || v_t.size() !== 0) begin
          n_bad++; $display("FAIL ovr_quiet: got nl=%0d v=%0d want 0/0", nl_t.size(), v_t.size());
        end
        n_cmp++;
        if (o_line_cnt !== 9'd479) begin n_bad++; $display("FAIL ovr_cnt_hold: got %0d want 479", o_line_cnt); end
      end
    end
  endtask

  task automatic test_odd_line();
    vsync_pulse();
    run_line(5, 8'hFF, 8'hFF);
    n_cmp++;
    if (v_t.size() !== (DEC ? 2 : 5)) begin
      n_bad++; $display("FAIL odd_valid_count: got %0d want %0d", v_t.size(), DEC ? 2 : 5);
    end
    for (int k = 0; k < v_t.size(); k++) begin
      n_cmp++;
      if (v_d[k] !== 9'h1FE) begin n_bad++; $display("FAIL odd_luma[%0d]: got %h want 1fe", k, v_d[k]); end
    end
    n_cmp++;
    if (nf_t.size() !== 1) begin n_bad++; $display("FAIL odd_new_frame: got %0d want 1", nf_t.size()); end
  endtask

  task automatic test_resync();
    vsync_pulse();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'h40);
    tick(1'b1, 1'b1, 8'h40);
    tick(1'b0, 1'b1, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    run_line(2, 8'h01, 8'h02);
    n_cmp++;
    if (nf_t.size() !== 1 || nl_cnt.size() !== 1 || nl_cnt[0] !== 9'd0) begin
      n_bad++; $display("FAIL resync_frame: got nf=%0d cnt=%0d want 1/0", nf_t.size(), o_line_cnt);
    end
    n_cmp++;
    if (v_t.size() !== (DEC ? 1 : 2)) begin
      n_bad++; $display("FAIL resync_valid_count: got %0d want %0d", v_t.size(), DEC ? 1 : 2);
    end else begin
      for (int k = 0; k < v_t.size(); k++) begin
        n_cmp++;
        if (v_d[k] !== (DEC ? 9'h003 : (k[0] ? 9'h004 : 9'h002))) begin
          n_bad++; $display("FAIL resync_luma[%0d]: got %h want %h", k, v_d[k], DEC ? 9'h003 : (k[0] ? 9'h004 : 9'h002));
        end
      end
    end
  endtask

  task automatic test_vsync_de_collide();
    clear_stats();
    tick(1'b1, 1'b1, 8'h55);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 8'h55);
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (nl_t.size() !== 0 || v_t.size() !== 0) begin
      n_bad++; $display("FAIL collide_no_start: got nl=%0d v=%0d want 0/0", nl_t.size(), v_t.size());
    end
    run_line(2, 8'h01, 8'h02);
    n_cmp++;
    if (nf_t.size() !== 1 || nl_cnt.size() !== 1 || nl_cnt[0] !== 9'd0) begin
      n_bad++; $display("FAIL collide_next_frame: got nf=%0d cnt=%0d want 1/0", nf_t.size(), o_line_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_full_line();
    test_overrun();
    test_odd_line();
    test_resync();
    test_vsync_de_collide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
